// File: rtl/wb_pkg.sv
// wb_pkg: writeback select encodings, buffer entry type and default buffer depth
package wb_pkg;
    localparam logic [1:0] WB_SEL_LD   = 2'b00;
    localparam logic [1:0] WB_SEL_ALU  = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_NONE = 2'b11;
    localparam int WB_FIFO_DEPTH = 2;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_skid_fifo.sv
// wb_skid_fifo: power-of-two ring buffer of {rd, data} entries with push/pop/count
module wb_skid_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  wb_entry_t     din,
    output wb_entry_t     dout,
    output logic [CW-1:0] count
);
    wb_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;

    // pointers are exactly AW bits wide, so they wrap modulo DEPTH for free
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file writeback arbiter (load > buffered ALU > direct ALU).
// Define WB_X0_FILTER_EN to drop writes to x0 and never buffer them.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_alu_valid,
    output logic        o_alu_ready,
    input  logic [4:0]  i_alu_rd,
    input  logic [1:0]  i_alu_wb_sel,
    input  logic [31:0] i_alu_data,
    input  logic [31:0] i_pc_plus_4,
    input  logic        i_ld_valid,
    input  logic [4:0]  i_ld_rd,
    input  logic [31:0] i_ld_data,
    output logic        o_rd_wren,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic        o_busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef WB_X0_FILTER_EN
    localparam bit X0_FILTER = 1'b1;
`else
    localparam bit X0_FILTER = 1'b0;
`endif

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_arbiter: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [CW-1:0] count;
    wb_entry_t     head, alu_ent, win_ent;
    logic          alu_wr, fifo_ne, push, pop, direct, win, wr_en;

    always_comb begin
        o_alu_ready = !i_reset && count < CW'(FIFO_DEPTH);
        alu_ent.rd = i_alu_rd;
        alu_ent.data = i_alu_wb_sel == WB_SEL_PC4 ? i_pc_plus_4 : i_alu_data;
        alu_wr = i_alu_valid && o_alu_ready
                 && (i_alu_wb_sel == WB_SEL_ALU || i_alu_wb_sel == WB_SEL_PC4)
                 && (!X0_FILTER || i_alu_rd != 5'd0);
        fifo_ne = count != '0;
        pop = !i_ld_valid && fifo_ne;
        direct = !i_ld_valid && !fifo_ne && alu_wr;
        push = alu_wr && !direct;
        win = i_ld_valid || pop || direct;
        win_ent = i_ld_valid ? '{rd: i_ld_rd, data: i_ld_data} : pop ? head : alu_ent;
        // an x0 winner still takes the slot; it just never reaches the register file
        wr_en = win && (!X0_FILTER || win_ent.rd != 5'd0);
    end

    wb_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst   (i_reset),
        .push  (push),
        .pop   (pop),
        .din   (alu_ent),
        .dout  (head),
        .count (count)
    );

    assign o_busy = fifo_ne;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rd_wren <= 1'b0;
            o_rd_addr <= '0;
            o_rd_data <= '0;
        end else begin
            o_rd_wren <= wr_en;
            if (wr_en) begin
                o_rd_addr <= win_ent.rd;
                o_rd_data <= win_ent.data;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table plus randomized traffic against a queue-based reference model
module tb_wb_arbiter;
    import wb_pkg::*;
    localparam int D = 2;
`ifdef WB_X0_FILTER_EN
    localparam bit F = 1'b1;
`else
    localparam bit F = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_reset = 1'b1, i_alu_valid = 1'b0, i_ld_valid = 1'b0;
    logic [4:0] i_alu_rd = '0, i_ld_rd = '0;
    logic [1:0] i_alu_wb_sel = '0;
    logic [31:0] i_alu_data = '0, i_pc_plus_4 = '0, i_ld_data = '0;
    logic o_alu_ready, o_rd_wren, o_busy;
    logic [4:0] o_rd_addr;
    logic [31:0] o_rd_data;

    always #5 i_clk = ~i_clk;

    wb_arbiter #(.FIFO_DEPTH(D)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
        .i_alu_rd(i_alu_rd), .i_alu_wb_sel(i_alu_wb_sel), .i_alu_data(i_alu_data),
        .i_pc_plus_4(i_pc_plus_4), .i_ld_valid(i_ld_valid), .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data),
        .o_rd_wren(o_rd_wren), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_busy(o_busy)
    );

    typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
    ent_t q[$];
    logic m_wren = 1'b0;
    logic [4:0] m_addr = '0;
    logic [31:0] m_data = '0;
    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // reference: the buffer is a queue; one register-file write per cycle, load first
    task automatic model_step();
        bit wants, win;
        logic [4:0] wrd;
        logic [31:0] wd;
        ent_t e;
        wrd = '0;
        wd = '0;
        win = 1'b1;
        if (i_reset) begin
            q.delete();
            m_wren = 1'b0;
            m_addr = '0;
            m_data = '0;
            return;
        end
        wants = i_alu_valid && q.size() < D && (i_alu_wb_sel == WB_SEL_ALU || i_alu_wb_sel == WB_SEL_PC4)
                && !(F && i_alu_rd == 5'd0);
        e.rd = i_alu_rd;
        e.data = i_alu_wb_sel == WB_SEL_PC4 ? i_pc_plus_4 : i_alu_data;
        if (i_ld_valid) begin
            wrd = i_ld_rd;
            wd = i_ld_data;
            if (wants) q.push_back(e);
        end else if (q.size() != 0) begin
            wrd = q[0].rd;
            wd = q[0].data;
            void'(q.pop_front());
            if (wants) q.push_back(e);
        end else if (wants) begin
            wrd = e.rd;
            wd = e.data;
        end else win = 1'b0;
        m_wren = win && !(F && wrd == 5'd0);
        if (m_wren) begin
            m_addr = wrd;
            m_data = wd;
        end
    endtask

    task automatic cyc(input logic rst, input logic av, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] ad, input logic [31:0] pc, input logic lv,
                       input logic [4:0] lrd, input logic [31:0] ld, output logic rdy);
        @(negedge i_clk);
        i_reset = rst; i_alu_valid = av; i_alu_rd = rd; i_alu_wb_sel = sel;
        i_alu_data = ad; i_pc_plus_4 = pc; i_ld_valid = lv; i_ld_rd = lrd; i_ld_data = ld;
        #1;
        rdy = o_alu_ready;
        chk("m_ready", 32'(o_alu_ready), 32'(!rst && q.size() < D));
        model_step();
        @(posedge i_clk);
        #1;
        chk("m_wren", 32'(o_rd_wren), 32'(m_wren));
        chk("m_addr", 32'(o_rd_addr), 32'(m_addr));
        chk("m_data", o_rd_data, m_data);
        chk("m_busy", 32'(o_busy), 32'(q.size() != 0));
    endtask

    typedef struct {
        logic rst, av; logic [4:0] rd; logic [1:0] sel; logic [31:0] ad, pc;
        logic lv; logic [4:0] lrd; logic [31:0] ld;
        logic rdy, wren; logic [4:0] addr; logic [31:0] data; logic busy;
    } vec_t;
    vec_t v[21];

    initial begin
        logic rdy;
        v[0]  = '{1'b1, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0};
        v[1]  = '{1'b1, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0};
        v[2]  = '{1'b0, 1'b1, 5'd5, 2'b01, 32'h1234, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd5, 32'h1234, 1'b0};
        v[3]  = '{1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd5, 32'h1234, 1'b0};
        v[4]  = '{1'b0, 1'b1, 5'd3, 2'b10, 32'hDEAD, 32'h104, 1'b1, 5'd7, 32'hAA, 1'b1, 1'b1, 5'd7, 32'hAA, 1'b1};
        v[5]  = '{1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd3, 32'h104, 1'b0};
        v[6]  = '{1'b0, 1'b1, 5'd9, 2'b00, 32'h55, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd3, 32'h104, 1'b0};
        v[7]  = '{1'b0, 1'b1, 5'd9, 2'b11, 32'h55, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd3, 32'h104, 1'b0};
        v[8]  = '{1'b0, 1'b1, 5'd10, 2'b01, 32'h10, 32'h0, 1'b1, 5'd11, 32'hB0, 1'b1, 1'b1, 5'd11, 32'hB0, 1'b1};
        v[9]  = '{1'b0, 1'b1, 5'd12, 2'b01, 32'h12, 32'h0, 1'b1, 5'd13, 32'hB1, 1'b1, 1'b1, 5'd13, 32'hB1, 1'b1};
        v[10] = '{1'b0, 1'b1, 5'd14, 2'b01, 32'h14, 32'h0, 1'b1, 5'd15, 32'hB2, 1'b0, 1'b1, 5'd15, 32'hB2, 1'b1};
        v[11] = '{1'b0, 1'b1, 5'd14, 2'b01, 32'h14, 32'h0, 1'b1, 5'd16, 32'hB3, 1'b0, 1'b1, 5'd16, 32'hB3, 1'b1};
        v[12] = '{1'b0, 1'b1, 5'd14, 2'b01, 32'h14, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd10, 32'h10, 1'b1};
        v[13] = '{1'b0, 1'b1, 5'd14, 2'b01, 32'h14, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd12, 32'h12, 1'b1};
        v[14] = '{1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd14, 32'h14, 1'b0};
        v[15] = '{1'b0, 1'b1, 5'd0, 2'b01, 32'h77, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, !F,
                  F ? 5'd14 : 5'd0, F ? 32'h14 : 32'h77, 1'b0};
        v[16] = '{1'b0, 1'b1, 5'd20, 2'b01, 32'h20, 32'h0, 1'b1, 5'd21, 32'hC1, 1'b1, 1'b1, 5'd21, 32'hC1, 1'b1};
        v[17] = '{1'b0, 1'b1, 5'd22, 2'b01, 32'h22, 32'h0, 1'b1, 5'd23, 32'hC3, 1'b1, 1'b1, 5'd23, 32'hC3, 1'b1};
        v[18] = '{1'b1, 1'b1, 5'd24, 2'b01, 32'h24, 32'h0, 1'b1, 5'd25, 32'hC5, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0};
        v[19] = '{1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0};
        v[20] = '{1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0};
        for (int i = 0; i < 21; i++) begin
            cyc(v[i].rst, v[i].av, v[i].rd, v[i].sel, v[i].ad, v[i].pc, v[i].lv, v[i].lrd, v[i].ld, rdy);
            chk($sformatf("v%0d_ready", i), 32'(rdy), 32'(v[i].rdy));
            chk($sformatf("v%0d_wren", i), 32'(o_rd_wren), 32'(v[i].wren));
            chk($sformatf("v%0d_addr", i), 32'(o_rd_addr), 32'(v[i].addr));
            chk($sformatf("v%0d_data", i), o_rd_data, v[i].data);
            chk($sformatf("v%0d_busy", i), 32'(o_busy), 32'(v[i].busy));
        end
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)),
                2'($urandom), $urandom, $urandom, $urandom_range(0, 9) < 4,
                5'($urandom_range(0, 31)), $urandom, rdy);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, meaning ALU-result buffer entries; the block SHALL accept only a power of two ≥2.
REQ-002 i_clk  input  1  meaning the single clock; all state SHALL update on its rising edge.
REQ-003 i_reset  input  1  meaning reset; it SHALL be synchronous and active-high.
REQ-004 i_alu_valid  input  1  meaning the ALU/jump completion request is valid.
REQ-005 o_alu_ready  output  1  meaning the block accepts the ALU request this cycle.
REQ-006 i_alu_rd  input  5  meaning the destination register of the ALU request.
REQ-007 i_alu_wb_sel  input  2  meaning writeback select: 00 load, 01 ALU, 10 PC+4, 11 none.
REQ-008 i_alu_data  input  32  meaning the ALU result.
REQ-009 i_pc_plus_4  input  32  meaning the link value for jumps.
REQ-010 i_ld_valid  input  1  meaning LSU load data is returning; this input SHALL NOT be back-pressured.
REQ-011 i_ld_rd  input  5  meaning the destination register of the load.
REQ-012 i_ld_data  input  32  meaning the load result.
REQ-013 o_rd_wren  output  1  meaning the register-file write enable.
REQ-014 o_rd_addr  output  5  meaning the register-file write address.
REQ-015 o_rd_data  output  32  meaning the register-file write data.
REQ-016 o_busy  output  1  meaning the ALU buffer is non-empty.

Function
REQ-017 The ALU handshake SHALL complete when i_alu_valid and o_alu_ready are both 1 in the same cycle.
REQ-018 Data SHALL be selected at acceptance: wb_sel 01 selects i_alu_data; 10 selects i_pc_plus_4.
REQ-019 An accepted request with wb_sel 00 or 11 SHALL be consumed without buffering or writing.
REQ-020 o_alu_ready SHALL be combinational and equal (count < FIFO_DEPTH).
REQ-021 Priority per cycle SHALL be: load first, then FIFO head, then the accepted ALU request direct (bypass only when the FIFO is empty).
REQ-022 An accepted writing ALU request that is not issued directly SHALL be pushed to the FIFO tail.
REQ-023 A push and a pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-024 The write outputs SHALL be registered with exactly one cycle of latency from the winning source to o_rd_wren/o_rd_addr/o_rd_data.
REQ-025 o_rd_wren SHALL be 0 in any cycle without a winner; o_rd_addr/o_rd_data then SHALL hold their previous values.
REQ-026 Full case (count=FIFO_DEPTH, i_ld_valid=1): the load SHALL be written, o_alu_ready SHALL be 0, and count SHALL stay at FIFO_DEPTH.
REQ-027 Full case (count=FIFO_DEPTH, no load): the head SHALL pop and o_alu_ready SHALL remain 0 that cycle.
REQ-028 Load and ALU in the same cycle with the FIFO empty: the load SHALL be written and the ALU entry pushed (count becomes 1).
REQ-029 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-030 While i_reset=1, count, pointers, o_rd_wren, o_busy, o_rd_addr and o_rd_data SHALL be 0.
REQ-031 While i_reset=1, o_alu_ready SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard buffered entries, and no write SHALL issue in the following cycle.

Configuration
REQ-033 With WB_X0_FILTER_EN defined, any winner with rd=0 SHALL be consumed with o_rd_wren=0, and an ALU rd=0 SHALL NOT be pushed.
REQ-034 Without WB_X0_FILTER_EN, rd=0 entries SHALL be handled exactly like other rd values.

Structure
REQ-035 Package wb_pkg SHALL hold the wb_sel encodings (WB_SEL_LD=00, WB_SEL_ALU=01, WB_SEL_PC4=10, WB_SEL_NONE=11) and the default FIFO depth.
REQ-036 Buffering SHALL live in one sub-module, wb_skid_fifo, carrying {rd, data}, with push/pop/count ports.

Verification
REQ-037 Scenario: ALU wb_sel=01, rd=5, data=0x1234, no load -> next cycle wren=1, addr=5, data=0x1234, o_busy=0.
REQ-038 Scenario: ALU wb_sel=10, pc_plus_4=0x104, and load rd=7 data=0xAA in the same cycle -> cycle+1 writes x7=0xAA; cycle+2 writes 0x104.
REQ-039 Scenario: loads on 4 consecutive cycles with ALU valid every cycle (depth 2) -> o_alu_ready drops after 2 accepts; buffered entries drain in order after the loads.
REQ-040 Scenario: ALU wb_sel=00 or 11 -> accepted with no write and count unchanged.
REQ-041 Scenario: rd=0 write -> wren=0 with WB_X0_FILTER_EN defined, wren=1 without it.
REQ-042 Scenario: reset while count=2 -> no writes afterwards; o_busy=0; o_alu_ready=1 after reset releases.
